// File: rtl/spm_pkg.sv
// Project arithmetic package: shared constants for the serial arithmetic
// blocks. No ports.
package spm_pkg;

  // Default width of the parallel multiplicand of the serial-parallel multiplier.
  localparam int unsigned SPM_SIZE_DEFAULT = 8;

  // States of the serial two's-complementer.
  typedef enum logic [0:0] {
    TC_PASS   = 1'b0,  // no 1 seen yet: bits pass unchanged
    TC_INVERT = 1'b1   // first 1 already passed: invert every later bit
  } tc_state_e;

endpackage

// File: rtl/spm_csa.sv
// One carry-save slice of the serial-parallel multiplier: partial product
// x_i & y_i is added to the incoming sum bit and the slice's own carry.
// The sum and carry are both held in flops.
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset, clears sum and carry
//   x_i       multiplicand bit of this slice
//   y_i       current serial multiplier bit
//   sum_in_i  registered sum from the next-higher slice
//   sum_o     registered sum of this slice
module spm_csa (
  input  logic clk_i,
  input  logic rst_i,
  input  logic x_i,
  input  logic y_i,
  input  logic sum_in_i,
  output logic sum_o
);

  logic pp;
  logic sum_d, sum_q;
  logic carry_d, carry_q;

  always_comb begin
    pp      = x_i & y_i;
    sum_d   = pp ^ sum_in_i ^ carry_q;
    carry_d = (pp & sum_in_i) | (pp & carry_q) | (sum_in_i & carry_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/spm.sv
// Serial-parallel two's-complement multiplier. x is a parallel signed word,
// y arrives serially LSB first, and the product leaves serially on p, LSB
// first, with product bit i valid right after operating edge i.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears all state and p
//   y    serial multiplier bit, LSB first
//   x    parallel two's-complement multiplicand (size bits)
//   p    registered serial product bit, LSB first
module spm
  import spm_pkg::*;
#(
  parameter int unsigned size = SPM_SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            y,
  input  logic [size-1:0] x,
  output logic            p
);

  // chain[k] is the registered sum of slice k; chain[size-1] is the output
  // of the two's-complementer for the MSB slice. Each slice consumes the
  // registered sum of the slice above, which keeps the weights aligned
  // (weight 2^(i+k) at edge i).
  logic [size-1:0] chain;

  // MSB slice: x[size-1] carries negative weight, so its partial-product
  // stream is negated serially (pass up to and including the first 1,
  // then invert). The result is registered like the other slices' sums.
  tc_state_e tc_state_d, tc_state_q;
  logic      tc_in;
  logic      tc_out_d, tc_out_q;

  always_comb begin
    tc_in      = x[size-1] & y;
    tc_out_d   = tc_in;
    tc_state_d = tc_state_q;
    unique case (tc_state_q)
      TC_PASS: begin
        tc_out_d = tc_in;
        if (tc_in) tc_state_d = TC_INVERT;
      end
      TC_INVERT: begin
        tc_out_d = ~tc_in;
      end
      default: begin
        tc_out_d   = tc_in;
        tc_state_d = TC_PASS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_state_q <= TC_PASS;
      tc_out_q   <= 1'b0;
    end else begin
      tc_state_q <= tc_state_d;
      tc_out_q   <= tc_out_d;
    end
  end

  assign chain[size-1] = tc_out_q;

  for (genvar k = 0; k < size - 1; k++) begin : g_slice
    spm_csa u_csa (
      .clk_i    (clk),
      .rst_i    (rst),
      .x_i      (x[k]),
      .y_i      (y),
      .sum_in_i (chain[k+1]),
      .sum_o    (chain[k])
    );
  end

  assign p = chain[0];

endmodule

// File: tb/tb_spm.sv
// Directed self-checking bench for spm with size = 8.
module tb_spm;

  logic       clk;
  logic       rst;
  logic       y;
  logic [7:0] x;
  logic       p;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [31:0] cap;

  spm #(.size(8)) dut (
    .clk (clk),
    .rst (rst),
    .y   (y),
    .x   (x),
    .p   (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One reset edge with y driven high, which must be ignored. Leaves rst
  // asserted just after the edge; the next run releases it on the negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    y   = 1'b1;
    @(posedge clk);
    #1;
    check(tag, {31'b0, p}, 32'h0);
  endtask

  // Releases reset, then streams n bits of ybits LSB first starting at
  // edge 0 and captures p after each edge.
  task automatic run(input logic [7:0] xv, input logic [31:0] ybits,
                     input int unsigned n, output logic [31:0] c);
    c = '0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      x   = xv;
      y   = ybits[i];
      @(posedge clk);
      #1;
      c[i] = p;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    y   = 1'b0;
    x   = 8'd0;

    // Reset, held for two edges with y=1.
    do_reset("reset_initial");
    do_reset("reset_hold");

    // 50 * 206 unsigned
    run(8'd50, 32'h0000_00CE, 16, cap);
    check("x50_yCE_unsigned", cap, 32'h0000_283C);

    // Reset from a state with live carries must still force p=0.
    do_reset("reset_after_run");

    // 50 * -50 (y sign-extended)
    run(8'd50, 32'hFFFF_FFCE, 16, cap);
    check("x50_yCE_signed", cap, 32'h0000_F63C);

    // -3 * 5, 24 bits: sign extension beyond 16 bits must stay 1
    do_reset("reset_before_m3");
    run(8'hFD, 32'h0000_0005, 24, cap);
    check("xm3_y5_low16", {16'b0, cap[15:0]}, 32'h0000_FFF1);
    check("xm3_y5_ext", {24'b0, cap[23:16]}, 32'h0000_00FF);

    // -3 * -5 = 15, upper bits stay 0
    do_reset("reset_before_m3m5");
    run(8'hFD, 32'hFFFF_FFFB, 24, cap);
    check("xm3_ym5", cap, 32'h0000_000F);

    // -128 * 255
    do_reset("reset_before_m128");
    run(8'h80, 32'h0000_00FF, 16, cap);
    check("xm128_yFF", cap, 32'h0000_8080);

    // 127 * 255
    do_reset("reset_before_127");
    run(8'h7F, 32'h0000_00FF, 16, cap);
    check("x127_yFF", cap, 32'h0000_7E81);

    // -128 * -128 = 16384
    do_reset("reset_before_m128m128");
    run(8'h80, 32'hFFFF_FF80, 16, cap);
    check("xm128_ym128", cap, 32'h0000_4000);

    // x=0 with an arbitrary y stream gives zeros
    do_reset("reset_before_x0");
    run(8'h00, 32'hA5C3_5A3C, 24, cap);
    check("x0_any_y", cap, 32'h0000_0000);

    // Abort mid-operation: edges 0..5 of 50*206, then reset at edge 6
    do_reset("reset_before_abort");
    run(8'd50, 32'h0000_00CE, 6, cap);
    check("abort_partial", {26'b0, cap[5:0]}, 32'h0000_003C);
    do_reset("reset_abort");
    run(8'd3, 32'h0000_0007, 16, cap);
    check("x3_y7_after_abort", cap, 32'h0000_0015);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spm.md
Name: spm

Overview:
Serial-parallel multiplier of size bits. The multiplicand x is a parallel two's-complement word. The multiplier y enters serially, LSB first, one bit per clock. The product leaves serially on p, LSB first, one bit per clock. It is a compact arithmetic datapath block for bit-serial pipelines: a carry-save adder chain with a serial two's-complementer on the x MSB slice.

Parameters:
size, 8, width of parallel multiplicand x; legal range 2..32; full product is 2*size bits.

Ports:
clk  input  1  rising-edge clock; all state updates on this edge.
rst  input  1  synchronous, active-high reset; clears all internal state and p.
y    input  1  serial multiplier bit, LSB first; sampled on each rising clk edge.
x    input  size  parallel multiplicand, two's complement; must stay stable for a whole multiplication.
p    output 1  serial product bit, LSB first; registered output.

Behaviour:
- Reset: on a rising edge with rst=1, clear every carry/sum flop and the two's-complementer state; p=0 from that edge on. y is ignored while rst=1.
- Cycle numbering: edge 0 is the first rising edge with rst=0. y sampled at edge i is multiplier bit i.
- Latency: after edge i, p holds product bit i until edge i+1. Bit 0 therefore appears right after the first operating edge; there is no added pipeline delay.
- Arithmetic: Y is the integer formed by the y bit stream (infinite precision; bits not driven are whatever the source supplies). p streams the two's-complement bits of signed(x) * Y.
- The first 2*size bits form the full product when y is zero-filled after size bits (Y unsigned) or sign-extended after size bits (Y signed).
- With y held 0 or held at the sign bit, p continues as the correct sign extension of the product indefinitely.
- Structure:
  - size bit slices; slice k ANDs x[k] with y.
  - Slices 0..size-2 are full-adder cells, each with sum and carry flops; each slice's sum feeds slice k-1.
  - Slice size-1 passes x[size-1]&y through a serial two's-complementer, which yields the negative weight of the x MSB.
  - p is the sum flop of slice 0.
- Starting a new multiplication requires one or more cycles of rst=1; there is no other start/done handshake.
- Changing x mid-operation gives an unspecified product; no error flag.
- Reset mid-operation aborts immediately; the next operation after reset release is unaffected by the aborted one.

Decomposition:
- No shared package types needed. Put the default size constant (8) in the project arithmetic package if one exists.
- One sub-module is natural: spm_csa, a 1-bit carry-save cell (AND partial product + full adder + sum/carry flops, synchronous reset), instantiated size-1 times.
- The serial two's-complementer (small FSM: pass bits unchanged until the first 1, then invert) stays inline in spm.

Test Plan:
- x=50, y stream 0xCE LSB first then zeros; capture p for 16 cycles from edge 0 -> 0x283C (10300).
- x=50, y stream 0xCE then ones (sign-extended -50) -> 16 captured bits 0xF63C (-2500).
- x=-3 (0xFD), y=5 zero-filled -> 0xFFF1 (-15); bits beyond 16 stay 1.
- x=-128 (0x80), y=0xFF zero-filled -> 0x8080 (-32640); x=127, y=0xFF -> 0x7E81.
- Reset: p=0 on the edge after rst=1 regardless of prior state. x=0 with any y -> all-zero stream.
- Reset mid-operation: run x=50, y=0xCE; assert rst for 1 cycle after edge 5. Then run x=3, y=7 -> captured 0x0015 (21), with no residue from the aborted run.
